sirv_gnrl_vr_fifo: RTL and testbench

General-purpose synchronous valid/ready FIFO that decouples a producer from a consumer: writer-side push handshake, reader-side pop handshake.
Storage entries use the team's load-enable, no-reset flops. Pointers and occupancy use the load-enable, reset-to-0 flops.
Used wherever a pipeline boundary needs buffering, e.g. between bus initiator and responder stages.

---
 rtl/sirv_gnrl_vr_fifo_pkg.sv | 16 +
 rtl/sirv_gnrl_dffs.sv | 38 +++
 rtl/sirv_gnrl_vr_fifo.sv | 99 +++++++++
 tb/tb_sirv_gnrl_vr_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sirv_gnrl_vr_fifo_pkg.sv
// Shared sizing helpers and legal-depth limits for the valid/ready FIFO.
package sirv_gnrl_vr_fifo_pkg;

    localparam int unsigned DP_MIN = 1;
    localparam int unsigned DP_MAX = 64;

    // Pointer width never collapses to zero bits, even for a single-entry FIFO.
    function automatic int unsigned ptr_width(input int unsigned dp);
        return (dp <= 1) ? 1 : $clog2(dp);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned dp);
        return $clog2(dp + 1);
    endfunction

endpackage

// File: rtl/sirv_gnrl_dffs.sv
// Codebase flop primitives: load-enable with reset-to-0, and load-enable without reset.
module sirv_gnrl_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    // rst_n is active-high in this codebase
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

module sirv_gnrl_dffl #(
    parameter int unsigned DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk
);

    always_ff @(posedge clk) begin
        if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_gnrl_vr_fifo.sv
// Synchronous valid/ready FIFO: push on i_vld&i_rdy, pop on o_vld&o_rdy, no write-to-read bypass.
module sirv_gnrl_vr_fifo
    import sirv_gnrl_vr_fifo_pkg::*;
#(
    parameter int unsigned DP        = 4,
    parameter int unsigned DW        = 32,
    parameter bit          CUT_READY = 1'b0,
    parameter bit          MSKO      = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_vld,
    output logic                        i_rdy,
    input  logic [DW-1:0]               i_dat,
    output logic                        o_vld,
    input  logic                        o_rdy,
    output logic [DW-1:0]               o_dat,
    output logic [cnt_width(DP)-1:0]    cnt,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PW = ptr_width(DP);
    localparam int unsigned CW = cnt_width(DP);

    logic [PW-1:0] wptr_r;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_r;
    logic [PW-1:0] rptr_nxt;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt;
    logic          push;
    logic          pop;
    logic          cnt_ld;
    logic [DW-1:0] mem [DP];

    assign full  = (cnt_r == CW'(DP));
    assign empty = (cnt_r == '0);
    assign o_vld = ~empty;
    assign cnt   = cnt_r;

    // CUT_READY=1 removes the o_rdy -> i_rdy path at the cost of no push-while-full
    assign i_rdy = CUT_READY ? ~full : (~full | o_rdy);

    assign push   = i_vld & i_rdy;
    assign pop    = o_vld & o_rdy;
    assign cnt_ld = push ^ pop;

    always_comb begin
        wptr_nxt = (wptr_r == PW'(DP - 1)) ? '0 : wptr_r + PW'(1);
        rptr_nxt = (rptr_r == PW'(DP - 1)) ? '0 : rptr_r + PW'(1);
        cnt_nxt  = push ? cnt_r + CW'(1) : cnt_r - CW'(1);
    end

    sirv_gnrl_dfflr #(.DW(PW)) u_wptr (
        .lden (push),
        .dnxt (wptr_nxt),
        .qout (wptr_r),
        .clk  (clk),
        .rst_n(rst_n)
    );

    sirv_gnrl_dfflr #(.DW(PW)) u_rptr (
        .lden (pop),
        .dnxt (rptr_nxt),
        .qout (rptr_r),
        .clk  (clk),
        .rst_n(rst_n)
    );

    sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
        .lden (cnt_ld),
        .dnxt (cnt_nxt),
        .qout (cnt_r),
        .clk  (clk),
        .rst_n(rst_n)
    );

    // Storage is never reset; occupancy alone decides what is reachable
    for (genvar i = 0; i < DP; i++) begin : g_mem
        sirv_gnrl_dffl #(.DW(DW)) u_ent (
            .lden (push && (wptr_r == PW'(i))),
            .dnxt (i_dat),
            .qout (mem[i]),
            .clk  (clk)
        );
    end

    assign o_dat = (MSKO && !o_vld) ? '0 : mem[rptr_r];

    a_dp_range: assert property (@(posedge clk) (DP >= DP_MIN) && (DP <= DP_MAX));
    a_cnt_max:  assert property (@(posedge clk) disable iff (rst_n) cnt_r <= CW'(DP));
    a_wptr_rng: assert property (@(posedge clk) disable iff (rst_n)
                                 {1'b0, wptr_r} < (PW + 1)'(DP));
    a_rptr_rng: assert property (@(posedge clk) disable iff (rst_n)
                                 {1'b0, rptr_r} < (PW + 1)'(DP));
    a_no_ovf:   assert property (@(posedge clk) disable iff (rst_n) !(push && full && !pop));

endmodule

// File: tb/tb_sirv_gnrl_vr_fifo.sv
// Scoreboard bench for sirv_gnrl_vr_fifo across three configurations sharing one clock and reset.
module tb_sirv_gnrl_vr_fifo;

    logic clk;
    logic rst_n;

    // instance 0: DP=4 CUT_READY=0 MSKO=0; 1: DP=4 CUT_READY=1 MSKO=1; 2: DP=3 CUT_READY=0 MSKO=0
    int dp_of   [3] = '{4, 4, 3};
    int cr_of   [3] = '{0, 1, 0};
    int msko_of [3] = '{0, 1, 0};

    logic       i_vld [3];
    logic       i_rdy [3];
    logic [7:0] i_dat [3];
    logic       o_vld [3];
    logic       o_rdy [3];
    logic [7:0] o_dat [3];
    logic       full  [3];
    logic       empty [3];
    logic [2:0] cnt0;
    logic [2:0] cnt1;
    logic [1:0] cnt2;
    int         cnt_v [3];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    int n_checks = 0;
    int n_errors = 0;

    always_comb begin
        cnt_v[0] = int'(cnt0);
        cnt_v[1] = int'(cnt1);
        cnt_v[2] = int'(cnt2);
    end

    sirv_gnrl_vr_fifo #(.DP(4), .DW(8), .CUT_READY(1'b0), .MSKO(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld[0]), .i_rdy(i_rdy[0]), .i_dat(i_dat[0]),
        .o_vld(o_vld[0]), .o_rdy(o_rdy[0]), .o_dat(o_dat[0]), .cnt(cnt0),
        .full(full[0]), .empty(empty[0])
    );

    sirv_gnrl_vr_fifo #(.DP(4), .DW(8), .CUT_READY(1'b1), .MSKO(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld[1]), .i_rdy(i_rdy[1]), .i_dat(i_dat[1]),
        .o_vld(o_vld[1]), .o_rdy(o_rdy[1]), .o_dat(o_dat[1]), .cnt(cnt1),
        .full(full[1]), .empty(empty[1])
    );

    sirv_gnrl_vr_fifo #(.DP(3), .DW(8), .CUT_READY(1'b0), .MSKO(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld[2]), .i_rdy(i_rdy[2]), .i_dat(i_dat[2]),
        .o_vld(o_vld[2]), .o_rdy(o_rdy[2]), .o_dat(o_dat[2]), .cnt(cnt2),
        .full(full[2]), .empty(empty[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int k, input logic [7:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endfunction

    // One cycle on instance k: drive after negedge, check outputs against the model, update the model.
    task automatic step(input int k, input logic vld, input logic [7:0] dat, input logic ordy);
        int         mc;
        logic       exp_rdy;
        logic       exp_push;
        logic       exp_pop;
        logic [7:0] head;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            i_vld[i] = 1'b0;
            i_dat[i] = 8'h00;
            o_rdy[i] = 1'b0;
        end
        i_vld[k] = vld;
        i_dat[k] = dat;
        o_rdy[k] = ordy;
        #1;
        mc       = qsize(k);
        exp_rdy  = (mc < dp_of[k]) || (cr_of[k] == 0 && ordy);
        exp_push = vld && exp_rdy;
        exp_pop  = (mc > 0) && ordy;
        n_checks++;
        if (o_vld[k] !== (mc > 0)) begin
            n_errors++;
            $display("FAIL o_vld inst%0d: got %b want %b", k, o_vld[k], (mc > 0));
        end
        n_checks++;
        if (i_rdy[k] !== exp_rdy) begin
            n_errors++;
            $display("FAIL i_rdy inst%0d: got %b want %b", k, i_rdy[k], exp_rdy);
        end
        n_checks++;
        if (cnt_v[k] != mc) begin
            n_errors++;
            $display("FAIL cnt inst%0d: got %0d want %0d", k, cnt_v[k], mc);
        end
        n_checks++;
        if (full[k] !== (mc == dp_of[k]) || empty[k] !== (mc == 0)) begin
            n_errors++;
            $display("FAIL full_empty inst%0d: got %b/%b want %b/%b", k, full[k], empty[k],
                     (mc == dp_of[k]), (mc == 0));
        end
        if (msko_of[k] != 0 && mc == 0) begin
            n_checks++;
            if (o_dat[k] !== 8'h00) begin
                n_errors++;
                $display("FAIL o_dat_mask inst%0d: got %h want 00", k, o_dat[k]);
            end
        end
        if (exp_pop) begin
            head = qpop(k);
            n_checks++;
            if (o_dat[k] !== head) begin
                n_errors++;
                $display("FAIL o_dat inst%0d: got %h want %h", k, o_dat[k], head);
            end
        end
        if (exp_push) qpush(k, dat);
    endtask

    task automatic drain(input int k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0, 8'h00, 1'b1);
        step(k, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_vld[k] !== 1'b0 || empty[k] !== 1'b1 || full[k] !== 1'b0 ||
                cnt_v[k] != 0 || i_rdy[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_state inst%0d: vld=%b empty=%b full=%b cnt=%0d rdy=%b want 0 1 0 0 1",
                         k, o_vld[k], empty[k], full[k], cnt_v[k], i_rdy[k]);
            end
        end
        n_checks++;
        if (o_dat[1] !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_odat_mask: got %h want 00", o_dat[1]);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(0, 1'b1, d[i], 1'b0);
        step(0, 1'b1, 8'hEE, 1'b0);
        drain(0, 4);
    endtask

    task automatic test_empty_latency();
        step(0, 1'b1, 8'hA5, 1'b1);
        step(0, 1'b0, 8'h00, 1'b1);
        step(0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_push_pop(input int k);
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(k, 1'b1, d[i], 1'b0);
        step(k, 1'b1, 8'h55, 1'b1);
        if (qsize(k) == 3) step(k, 1'b1, 8'h55, 1'b0);
        drain(k, 4);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) step(2, 1'b1, 8'(i), 1'b1);
        drain(2, 2);
    endtask

    task automatic test_reset_mid();
        step(1, 1'b1, 8'h61, 1'b0);
        step(1, 1'b1, 8'h62, 1'b0);
        step(1, 1'b0, 8'h00, 1'b0);
        #3;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (o_vld[1] !== 1'b0 || cnt_v[1] != 0 || i_rdy[1] !== 1'b1 || o_dat[1] !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: vld=%b cnt=%0d rdy=%b dat=%h want 0 0 1 00",
                     o_vld[1], cnt_v[1], i_rdy[1], o_dat[1]);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst_n = 1'b0;
        step(1, 1'b1, 8'h77, 1'b0);
        step(1, 1'b1, 8'h78, 1'b0);
        drain(1, 2);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_vld[i] = 1'b0;
            i_dat[i] = 8'h00;
            o_rdy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b0;
        test_reset();
        test_fill_drain();
        test_empty_latency();
        test_full_push_pop(0);
        test_full_push_pop(1);
        test_wrap();
        test_reset_mid();
        n_checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_scoreboard: got %0d entries want 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
